// File: rtl/motion_cmd_sequencer_if.sv
// Command channel between the motion backend and the sequencer.
// Valid/ready handshake; a command moves on any rising edge where both are high.
interface motion_cmd_sequencer_if #(
  parameter int DUR_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, output cmd_op, output cmd_dur, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_dur, output cmd_ready);
endinterface

// File: rtl/motion_cmd_sequencer.sv
// Motion command sequencer: queues timed motion commands (op + duration in ticks)
// and plays them back one at a time on one-hot motor driver lines. A stop
// dead-time is inserted between differing motion ops, and an emergency stop
// aborts the running command and flushes the queue.
module motion_cmd_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int DUR_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic                             clk,
  input  logic                             rst_n,
  motion_cmd_sequencer_if.slave            cmd,
  input  logic                             estop,
  output logic                             fwd_out,
  output logic                             bwd_out,
  output logic                             left_out,
  output logic                             right_out,
  output logic                             stop_out,
  output logic                             cmd_done,
  output logic                             cmd_err,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PW    = $clog2(TICK_DIV);
  localparam int DT_W  = $clog2(DEAD_TICKS + 2);
  localparam int TW    = (DUR_W > DT_W) ? DUR_W : DT_W;

  localparam logic [2:0] OP_STOP  = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_BWD   = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  // Output vector order: {stop, right, left, bwd, fwd}
  localparam logic [4:0] OUT_STOP = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_mem  [FIFO_DEPTH];
  logic [DUR_W-1:0] dur_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       prev_op_q, prev_op_d, cur_op_q, cur_op_d;
  logic [DUR_W-1:0] hold_dur_q, hold_dur_d;
  logic [TW-1:0]    ticks_q, ticks_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [4:0]       outs_q, outs_d;

  logic             push, pop, run_last, dead_last, bad_op;
  logic [2:0]       eff_prev, head_op;
  logic [DUR_W-1:0] head_dur;

  function automatic logic is_motion(input logic [2:0] op);
    return (op >= OP_FWD) && (op <= OP_RIGHT);
  endfunction

  // Queue storage; written on every accepted command, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]  <= cmd.cmd_op;
      dur_mem[wr_ptr_q] <= cmd.cmd_dur;
    end
  end

  // Next-state: tick timing, launch decisions, queue bookkeeping, estop override
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    prev_op_d  = prev_op_q;
    cur_op_d   = cur_op_q;
    hold_dur_d = hold_dur_q;
    ticks_d    = ticks_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pop        = 1'b0;
    push       = cmd.cmd_valid && ready_q && !estop;
    run_last   = (state_q == S_RUN)  && (ticks_q == TW'(1)) && (presc_q == PW'(TICK_DIV - 1));
    dead_last  = (state_q == S_DEAD) && (ticks_q == TW'(1)) && (presc_q == PW'(TICK_DIV - 1));
    // At the end of a run the finishing op is what the next command follows
    eff_prev   = run_last ? cur_op_q : prev_op_q;
    head_op    = op_mem[rd_ptr_q];
    head_dur   = dur_mem[rd_ptr_q];
    bad_op     = head_op > OP_RIGHT;

    if ((state_q == S_RUN) || (state_q == S_DEAD)) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        ticks_d = ticks_q - TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Registered done must be visible during the last RUN cycle, so look one cycle ahead
    if ((state_q == S_RUN) && (ticks_q == TW'(1)) && (presc_q == PW'(TICK_DIV - 2))) begin
      done_d = 1'b1;
    end

    if (run_last) begin
      state_d   = S_IDLE;
      prev_op_d = (count_q == '0) ? OP_STOP : cur_op_q;
    end

    if (dead_last) begin
      state_d = S_RUN;
      presc_d = '0;
      ticks_d = TW'(hold_dur_q);
    end

    if (state_q == S_HALT) begin
      state_d = S_IDLE;
    end

    if (((state_q == S_IDLE) || run_last) && (count_q != '0)) begin
      pop      = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head_dur == '0) begin
        done_d = 1'b1;
        if (run_last && (count_q == CW'(1))) begin
          prev_op_d = OP_STOP;
        end
      end else begin
        err_d    = bad_op;
        cur_op_d = bad_op ? OP_STOP : head_op;
        presc_d  = '0;
        if (is_motion(head_op) && is_motion(eff_prev) && (head_op != eff_prev) && (DEAD_TICKS > 0)) begin
          state_d    = S_DEAD;
          ticks_d    = TW'(DEAD_TICKS);
          hold_dur_d = head_dur;
        end else begin
          state_d = S_RUN;
          ticks_d = TW'(head_dur);
        end
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Emergency stop wins over everything decided above
    if (estop) begin
      state_d   = S_HALT;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      prev_op_d = OP_STOP;
      cur_op_d  = OP_STOP;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end

    outs_d = OUT_STOP;
    if (state_d == S_RUN) begin
      case (cur_op_d)
        OP_FWD:   outs_d = 5'b00001;
        OP_BWD:   outs_d = 5'b00010;
        OP_LEFT:  outs_d = 5'b00100;
        OP_RIGHT: outs_d = 5'b01000;
        default:  outs_d = OUT_STOP;
      endcase
    end

    ready_d = (count_d < CW'(FIFO_DEPTH)) && !estop;
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  // FSM state, queue control and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_op_q  <= OP_STOP;
      cur_op_q   <= OP_STOP;
      hold_dur_q <= '0;
      ticks_q    <= '0;
      presc_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      outs_q     <= OUT_STOP;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_op_q  <= prev_op_d;
      cur_op_q   <= cur_op_d;
      hold_dur_q <= hold_dur_d;
      ticks_q    <= ticks_d;
      presc_q    <= presc_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      outs_q     <= outs_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign fwd_out       = outs_q[0];
  assign bwd_out       = outs_q[1];
  assign left_out      = outs_q[2];
  assign right_out     = outs_q[3];
  assign stop_out      = outs_q[4];
  assign cmd_done      = done_q;
  assign cmd_err       = err_q;
  assign busy          = busy_q;
  assign fifo_count    = count_q;
endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Scoreboard bench for motion_cmd_sequencer (TICK_DIV=4, DEAD_TICKS=2, FIFO_DEPTH=4).
// Stimulus pushes expected output segments and done/err pulse cycles into queues;
// a negedge monitor pops and compares as the DUT produces them.
module tb_motion_cmd_sequencer;
  localparam int TICK_DIV = 4, DUR_W = 8, FIFO_DEPTH = 4, DEAD_TICKS = 2;
  localparam int C_STOP = 0, C_FWD = 1, C_BWD = 2, C_LEFT = 3, C_RIGHT = 4, C_BAD = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic estop = 1'b0;
  logic fwd_out, bwd_out, left_out, right_out, stop_out, cmd_done, cmd_err, busy;
  logic [2:0] fifo_count;

  motion_cmd_sequencer_if #(.DUR_W(DUR_W)) cmd_if ();

  motion_cmd_sequencer #(
    .TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .FIFO_DEPTH(FIFO_DEPTH), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .estop(estop),
    .fwd_out(fwd_out), .bwd_out(bwd_out), .left_out(left_out), .right_out(right_out),
    .stop_out(stop_out), .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
    .fifo_count(fifo_count)
  );

  initial forever #5 clk = ~clk;

  // Edge counter: at a negedge, edge_n is the index of the last rising edge;
  // the cycle being observed is numbered edge_n+1.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int passed = 0;
  int total = 0;

  typedef struct {int code; int start; int len;} seg_t;
  seg_t exp_seg[$];
  int   exp_done[$];
  int   exp_err[$];

  int   cur_code = C_STOP;
  int   seg_start = 1;
  int   seg_len = 0;
  int   onehot_bad = 0;
  int   mon_code;
  seg_t mon_s;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, edge_n + 1);
  endtask

  // start < 0 or len == 0 mean "don't care"
  task automatic exp_push(input int code, input int start, input int len);
    seg_t s;
    s.code = code; s.start = start; s.len = len;
    exp_seg.push_back(s);
  endtask

  always @(negedge clk) begin
    case ({stop_out, right_out, left_out, bwd_out, fwd_out})
      5'b10000: mon_code = C_STOP;
      5'b00001: mon_code = C_FWD;
      5'b00010: mon_code = C_BWD;
      5'b00100: mon_code = C_LEFT;
      5'b01000: mon_code = C_RIGHT;
      default: begin mon_code = C_BAD; onehot_bad++; end
    endcase
    if (mon_code != cur_code) begin
      if (exp_seg.size() == 0) begin
        check("seg_unexpected", cur_code, -1);
      end else begin
        mon_s = exp_seg.pop_front();
        check("seg_code", cur_code, mon_s.code);
        if (mon_s.start >= 0) check("seg_start", seg_start, mon_s.start);
        if (mon_s.len > 0) check("seg_len", seg_len, mon_s.len);
      end
      cur_code  = mon_code;
      seg_start = edge_n + 1;
      seg_len   = 0;
    end
    seg_len++;
    if (cmd_done === 1'b1) begin
      if (exp_done.size() == 0) check("done_unexpected", edge_n + 1, -1);
      else check("done_cycle", edge_n + 1, exp_done.pop_front());
    end
    if (cmd_err === 1'b1) begin
      if (exp_err.size() == 0) check("err_unexpected", edge_n + 1, -1);
      else check("err_cycle", edge_n + 1, exp_err.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge k.
  task automatic push_cmd(input int op, input int dur, output int k);
    int budget;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'(op);
    cmd_if.cmd_dur   = DUR_W'(dur);
    budget = 200;
    while (cmd_if.cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("push_timeout", 0, 1);
    k = edge_n + 1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 400;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check(name, 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k, k0, k5;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_dur   = '0;
    exp_push(C_STOP, -1, 0);

    // Reset and release
    repeat (3) @(negedge clk);
    check("rst_stop_out", stop_out, 1);
    check("rst_cmd_ready", cmd_if.cmd_ready, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_done", cmd_done, 0);
    rst_n = 1'b1;
    check("ready_before_edge", cmd_if.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", cmd_if.cmd_ready, 1);
    check("busy_after_release", busy, 0);

    // Single FWD/3: 12 fwd cycles k+2..k+13, done at k+13
    push_cmd(C_FWD, 3, k);
    exp_push(C_FWD, k + 2, 12);
    exp_push(C_STOP, -1, 0);
    exp_done.push_back(k + 13);
    wait_idle("idle_timeout_single");

    // FWD/2 then BWD/2: 8 fwd, 8 stop dead-time, 8 bwd
    push_cmd(C_FWD, 2, k0);
    exp_push(C_FWD, k0 + 2, 8);
    exp_push(C_STOP, k0 + 10, 8);
    exp_push(C_BWD, k0 + 18, 8);
    exp_push(C_STOP, -1, 0);
    exp_done.push_back(k0 + 9);
    exp_done.push_back(k0 + 25);
    push_cmd(C_BWD, 2, k);
    wait_idle("idle_timeout_dirchange");

    // FWD/2 then FWD/2: 16 continuous fwd cycles
    push_cmd(C_FWD, 2, k0);
    exp_push(C_FWD, k0 + 2, 16);
    exp_push(C_STOP, -1, 0);
    exp_done.push_back(k0 + 9);
    exp_done.push_back(k0 + 17);
    push_cmd(C_FWD, 2, k);
    wait_idle("idle_timeout_same");

    // Queue full: LEFT/10 running, then 5 x LEFT/1
    push_cmd(C_LEFT, 10, k0);
    exp_push(C_LEFT, k0 + 2, 60);
    exp_push(C_STOP, -1, 0);
    exp_done.push_back(k0 + 41);
    for (int i = 0; i < 5; i++) exp_done.push_back(k0 + 45 + 4 * i);
    for (int i = 0; i < 4; i++) push_cmd(C_LEFT, 1, k);
    check("full_fifo_count", fifo_count, 4);
    check("full_cmd_ready", cmd_if.cmd_ready, 0);
    check("full_busy", busy, 1);
    push_cmd(C_LEFT, 1, k5);
    check("held_push_edge", k5, k0 + 42);
    wait_idle("idle_timeout_full");

    // Emergency stop mid-RUN with 3 queued
    push_cmd(C_BWD, 10, k0);
    exp_push(C_BWD, k0 + 2, 10);
    exp_push(C_STOP, -1, 0);
    for (int i = 0; i < 3; i++) push_cmd(C_FWD, 1, k);
    check("estop_pre_count", fifo_count, 3);
    while (edge_n < k0 + 10) @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    check("estop_stop_out", stop_out, 1);
    check("estop_fifo_count", fifo_count, 0);
    check("estop_cmd_ready", cmd_if.cmd_ready, 0);
    check("estop_busy", busy, 1);
    repeat (3) @(negedge clk);
    check("estop_hold_ready", cmd_if.cmd_ready, 0);
    estop = 1'b0;
    @(negedge clk);
    check("release_cmd_ready", cmd_if.cmd_ready, 1);
    check("release_busy", busy, 0);
    check("release_fifo_count", fifo_count, 0);
    repeat (3) @(negedge clk);

    // dur=0 discard: done only, outputs stay stop
    push_cmd(C_FWD, 0, k);
    exp_done.push_back(k + 2);
    wait_idle("idle_timeout_discard");

    // Invalid op 6, dur 1: err pulse, 4 stop cycles, then done
    push_cmd(6, 1, k);
    exp_err.push_back(k + 2);
    exp_done.push_back(k + 5);
    wait_idle("idle_timeout_invalid");

    check("onehot_violations", onehot_bad, 0);
    check("seg_left_over", exp_seg.size(), 1);
    check("done_left_over", exp_done.size(), 0);
    check("err_left_over", exp_err.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
